// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage.
//   - alu_op encodings and R-type funct constants
//   - alu_fn_e: internal ALU function after decode
//   - state_e: execute-stage FSM states
//   - forward-select encodings (used when EX_FWD_EN is defined)
package ex_pkg;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  // Forward-select: 10 takes the EX/MEM value, 01 the MEM/WB value,
  // 00 and 11 both keep the register-file value.
  localparam logic [1:0] FWD_NONE     = 2'b00;
  localparam logic [1:0] FWD_MEMWB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM    = 2'b10;
  localparam logic [1:0] FWD_NONE_ALT = 2'b11;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_MUL,
    ALU_NONE
  } alu_fn_e;

  typedef enum logic {
    ST_IDLE,
    ST_MUL_BUSY
  } state_e;

  // Map alu_op plus funct onto the internal ALU function. Unknown
  // funct codes map to ALU_NONE, which produces a zero result.
  function automatic alu_fn_e decodeAluFn(input logic [1:0] aluOp,
                                          input logic [5:0] funct);
    alu_fn_e fn;
    fn = ALU_NONE;
    case (aluOp)
      ALU_OP_ADD: fn = ALU_ADD;
      ALU_OP_SUB: fn = ALU_SUB;
      ALU_OP_OR:  fn = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: fn = ALU_ADD;
          FUNCT_SUB: fn = ALU_SUB;
          FUNCT_AND: fn = ALU_AND;
          FUNCT_OR:  fn = ALU_OR;
          FUNCT_SLT: fn = ALU_SLT;
          FUNCT_MUL: fn = ALU_MUL;
          default:   fn = ALU_NONE;
        endcase
      end
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/ex_mem_stage_alu.sv
// ex_alu: single-cycle combinational ALU (ADD/SUB/AND/OR/signed SLT).
// Ports:
//   fn_i      decoded ALU function
//   a_i, b_i  operands
//   result_o  result; zero for ALU_MUL/ALU_NONE (multiply lives elsewhere)
module ex_alu
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_fn_e         fn_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  // Plain function select; ADD/SUB wrap naturally at XLEN bits.
  always_comb begin
    result_o = '0;
    case (fn_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLT: result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage plus the EX/MEM pipeline register, with an
// iterative shift-add multiplier that stalls upstream while it runs.
// Optional feature macro: EX_FWD_EN adds operand forwarding ports.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              kill the current EX operation (bubble next edge)
//   wb_in/mem_in/ex_in ID/EX control fields
//   npc_in, rs_val, rt_val, imm, rt_idx, rd_idx   ID/EX data fields
//   stall              hold PC, IF/ID and ID/EX this cycle
//   wb_out, mem_out, branch_target, zero, alu_result, store_data, dest_reg
//                      registered EX/MEM outputs
//   fwd_a, fwd_b, exmem_fwd, memwb_fwd   forwarding inputs (EX_FWD_EN)
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int MUL_CYCLES = 32,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [1:0]      wb_in,
  input  logic [2:0]      mem_in,
  input  logic [3:0]      ex_in,
  input  logic [XLEN-1:0] npc_in,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rt_idx,
  input  logic [4:0]      rd_idx,
`ifdef EX_FWD_EN
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic [XLEN-1:0] exmem_fwd,
  input  logic [XLEN-1:0] memwb_fwd,
`endif
  output logic            stall,
  output logic [1:0]      wb_out,
  output logic [2:0]      mem_out,
  output logic [XLEN-1:0] branch_target,
  output logic            zero,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      dest_reg
);

  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  logic [XLEN-1:0] opA, rtFwd, opB, aluRes, branchCalc, prodStep;
  logic [4:0]      destSel;
  alu_fn_e         aluFn;
  logic            isMul, stallRaw;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
  logic [1:0]      mulWb_q, mulWb_d;
  logic [2:0]      mulMem_q, mulMem_d;
  logic [4:0]      mulDest_q, mulDest_d;
  logic [XLEN-1:0] mulTarget_q, mulTarget_d, mulStore_q, mulStore_d;

  logic [1:0]      wb_q, wb_d;
  logic [2:0]      mem_q, mem_d;
  logic [XLEN-1:0] target_q, target_d, result_q, result_d, store_q, store_d;
  logic            zero_q, zero_d;
  logic [4:0]      dest_q, dest_d;

`ifdef EX_FWD_EN
  // Operand forwarding; 00 and 11 both fall through to the register value.
  always_comb begin
    opA = rs_val;
    case (fwd_a)
      FWD_EXMEM: opA = exmem_fwd;
      FWD_MEMWB: opA = memwb_fwd;
      default:   opA = rs_val;
    endcase
  end

  always_comb begin
    rtFwd = rt_val;
    case (fwd_b)
      FWD_EXMEM: rtFwd = exmem_fwd;
      FWD_MEMWB: rtFwd = memwb_fwd;
      default:   rtFwd = rt_val;
    endcase
  end
`else
  assign opA   = rs_val;
  assign rtFwd = rt_val;
`endif

  assign opB        = ex_in[0] ? imm : rtFwd;
  assign aluFn      = decodeAluFn(ex_in[2:1], imm[5:0]);
  assign isMul      = (aluFn == ALU_MUL);
  assign destSel    = ex_in[3] ? rd_idx : rt_idx;
  assign branchCalc = npc_in + {imm[XLEN-3:0], 2'b00};
  // Partial product after this cycle's step; on the last step it is the
  // full low-XLEN product.
  assign prodStep   = prod_q + (mplier_q[0] ? mcand_q : '0);

  ex_alu #(.XLEN(XLEN)) u_alu (
    .fn_i    (aluFn),
    .a_i     (opA),
    .b_i     (opB),
    .result_o(aluRes)
  );

  // Next-state and EX/MEM load logic. The EX/MEM fields default to a
  // bubble (all zero); only a normal op or a finished multiply loads data.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    mulWb_d     = mulWb_q;
    mulMem_d    = mulMem_q;
    mulDest_d   = mulDest_q;
    mulTarget_d = mulTarget_q;
    mulStore_d  = mulStore_q;
    wb_d        = '0;
    mem_d       = '0;
    target_d    = '0;
    result_d    = '0;
    store_d     = '0;
    zero_d      = 1'b0;
    dest_d      = '0;
    stallRaw    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (isMul) begin
          stallRaw    = 1'b1;
          state_d     = ST_MUL_BUSY;
          cnt_d       = '0;
          mcand_d     = opA;
          mplier_d    = opB;
          prod_d      = '0;
          mulWb_d     = wb_in;
          mulMem_d    = mem_in;
          mulDest_d   = destSel;
          mulTarget_d = branchCalc;
          mulStore_d  = rtFwd;
        end else begin
          wb_d     = wb_in;
          mem_d    = mem_in;
          target_d = branchCalc;
          result_d = aluRes;
          zero_d   = (aluRes == '0);
          store_d  = rtFwd;
          dest_d   = destSel;
        end
      end
      ST_MUL_BUSY: begin
        stallRaw = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          prod_d   = prodStep;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d  = ST_IDLE;
            wb_d     = mulWb_q;
            mem_d    = mulMem_q;
            target_d = mulTarget_q;
            result_d = prodStep;
            zero_d   = (prodStep == '0);
            store_d  = mulStore_q;
            dest_d   = mulDest_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset has priority over any issue in flight, so mask stall during it.
  assign stall = stallRaw & ~rst;

  // State, multiplier and EX/MEM registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      mulWb_q     <= '0;
      mulMem_q    <= '0;
      mulDest_q   <= '0;
      mulTarget_q <= '0;
      mulStore_q  <= '0;
      wb_q        <= '0;
      mem_q       <= '0;
      target_q    <= '0;
      result_q    <= '0;
      store_q     <= '0;
      zero_q      <= 1'b0;
      dest_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      mulWb_q     <= mulWb_d;
      mulMem_q    <= mulMem_d;
      mulDest_q   <= mulDest_d;
      mulTarget_q <= mulTarget_d;
      mulStore_q  <= mulStore_d;
      wb_q        <= wb_d;
      mem_q       <= mem_d;
      target_q    <= target_d;
      result_q    <= result_d;
      store_q     <= store_d;
      zero_q      <= zero_d;
      dest_q      <= dest_d;
    end
  end

  assign wb_out        = wb_q;
  assign mem_out       = mem_q;
  assign branch_target = target_q;
  assign zero          = zero_q;
  assign alu_result    = result_q;
  assign store_data    = store_q;
  assign dest_reg      = dest_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed plus randomized checks of ex_mem_stage against
// an arithmetic reference model. Define EX_FWD_EN to include forwarding.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [1:0]  wb_in;
  logic [2:0]  mem_in;
  logic [3:0]  ex_in;
  logic [31:0] npc_in, rs_val, rt_val, imm;
  logic [4:0]  rt_idx, rd_idx;
  logic        stall, zero;
  logic [1:0]  wb_out;
  logic [2:0]  mem_out;
  logic [31:0] branch_target, alu_result, store_data;
  logic [4:0]  dest_reg;
`ifdef EX_FWD_EN
  logic [1:0]  fwd_a = 2'b00, fwd_b = 2'b00;
  logic [31:0] exmem_fwd = 32'd0, memwb_fwd = 32'd0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wb_in        (wb_in),
    .mem_in       (mem_in),
    .ex_in        (ex_in),
    .npc_in       (npc_in),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .imm          (imm),
    .rt_idx       (rt_idx),
    .rd_idx       (rd_idx),
`ifdef EX_FWD_EN
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .exmem_fwd    (exmem_fwd),
    .memwb_fwd    (memwb_fwd),
`endif
    .stall        (stall),
    .wb_out       (wb_out),
    .mem_out      (mem_out),
    .branch_target(branch_target),
    .zero         (zero),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .dest_reg     (dest_reg)
  );

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input string field,
                             input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s.%s observed=0x%0h expected=0x%0h", tag, field, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic [1:0] wb, input logic [2:0] mem,
                               input logic [3:0] ex, input logic [31:0] npc,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [31:0] im, input logic [4:0] rti,
                               input logic [4:0] rdi);
    flush  = f;
    wb_in  = wb;
    mem_in = mem;
    ex_in  = ex;
    npc_in = npc;
    rs_val = rs;
    rt_val = rt;
    imm    = im;
    rt_idx = rti;
    rd_idx = rdi;
  endtask

  task automatic applyNop();
    applyStimulus(1'b0, 2'b10, 3'b000, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
  endtask

  // Random ID/EX contents while the multiplier is busy; they must be ignored.
  task automatic scramble();
    logic [31:0] r;
    r = $urandom;
    applyStimulus(1'b0, r[1:0], r[4:2], r[8:5], $urandom, $urandom, $urandom,
                  $urandom, r[13:9], r[18:14]);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] modelOpA();
`ifdef EX_FWD_EN
    if (fwd_a == 2'b10) return exmem_fwd;
    if (fwd_a == 2'b01) return memwb_fwd;
`endif
    return rs_val;
  endfunction

  function automatic logic [31:0] modelRt();
`ifdef EX_FWD_EN
    if (fwd_b == 2'b10) return exmem_fwd;
    if (fwd_b == 2'b01) return memwb_fwd;
`endif
    return rt_val;
  endfunction

  function automatic logic [31:0] modelResult();
    logic [31:0] a, b;
    logic [63:0] p;
    a = modelOpA();
    b = ex_in[0] ? imm : modelRt();
    p = {32'd0, a} * {32'd0, b};
    case (ex_in[2:1])
      2'b00: return a + b;
      2'b01: return a - b;
      2'b11: return a | b;
      default: begin
        case (imm[5:0])
          6'h20: return a + b;
          6'h22: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h18: return p[31:0];
          default: return 32'd0;
        endcase
      end
    endcase
  endfunction

  // Check a single-cycle load against the currently applied inputs.
  task automatic checkLoad(input string tag);
    logic [31:0] res;
    if (flush) begin
      checkOutput(tag, "wb_bubble", {30'd0, wb_out}, 32'd0);
      checkOutput(tag, "mem_bubble", {29'd0, mem_out}, 32'd0);
    end else begin
      res = modelResult();
      checkOutput(tag, "wb", {30'd0, wb_out}, {30'd0, wb_in});
      checkOutput(tag, "mem", {29'd0, mem_out}, {29'd0, mem_in});
      checkOutput(tag, "alu", alu_result, res);
      checkOutput(tag, "zero", {31'd0, zero}, (res == 32'd0) ? 32'd1 : 32'd0);
      checkOutput(tag, "target", branch_target, npc_in + (imm << 2));
      checkOutput(tag, "store", store_data, modelRt());
      checkOutput(tag, "dest", {27'd0, dest_reg}, {27'd0, (ex_in[3] ? rd_idx : rt_idx)});
    end
  endtask

  // Run a multiply already applied on the inputs: stall for 33 cycles with
  // bubbles, then the product with the controls captured at issue.
  task automatic runMul(input string tag);
    logic [31:0] expRes;
    logic [1:0]  expWb;
    logic [2:0]  expMem;
    logic [4:0]  expDest;
    expRes  = modelResult();
    expWb   = wb_in;
    expMem  = mem_in;
    expDest = ex_in[3] ? rd_idx : rt_idx;
    #1;
    for (int c = 0; c < 33; c++) begin
      checkOutput(tag, "stall", {31'd0, stall}, 32'd1);
      tick();
      if (c < 32) begin
        checkOutput(tag, "wb_bubble", {30'd0, wb_out}, 32'd0);
        checkOutput(tag, "mem_bubble", {29'd0, mem_out}, 32'd0);
        scramble();
        #1;
      end
    end
    checkOutput(tag, "product", alu_result, expRes);
    checkOutput(tag, "zero", {31'd0, zero}, (expRes == 32'd0) ? 32'd1 : 32'd0);
    checkOutput(tag, "wb", {30'd0, wb_out}, {30'd0, expWb});
    checkOutput(tag, "mem", {29'd0, mem_out}, {29'd0, expMem});
    checkOutput(tag, "dest", {27'd0, dest_reg}, {27'd0, expDest});
    applyNop();
    #1;
    checkOutput(tag, "stall_drop", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [5:0]  functs [6];
    logic        sawProd;
    functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24;
    functs[3] = 6'h25; functs[4] = 6'h2A; functs[5] = 6'h3F;

    // Reset state
    rst = 1'b1;
    applyStimulus(1'b0, 2'b00, 3'b000, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    tick();
    tick();
    checkOutput("reset", "stall", {31'd0, stall}, 32'd0);
    checkOutput("reset", "wb", {30'd0, wb_out}, 32'd0);
    checkOutput("reset", "mem", {29'd0, mem_out}, 32'd0);
    checkOutput("reset", "alu", alu_result, 32'd0);
    checkOutput("reset", "zero", {31'd0, zero}, 32'd0);
    checkOutput("reset", "target", branch_target, 32'd0);
    checkOutput("reset", "store", store_data, 32'd0);
    checkOutput("reset", "dest", {27'd0, dest_reg}, 32'd0);
    rst = 1'b0;

    // R-type ADD wrapping: 7 + 0xFFFFFFFF = 6
    applyStimulus(1'b0, 2'b10, 3'b000, 4'b1100, 32'h40, 32'd7, 32'hFFFF_FFFF,
                  32'h20, 5'd9, 5'd5);
    tick();
    checkOutput("add", "alu_const", alu_result, 32'd6);
    checkOutput("add", "dest_const", {27'd0, dest_reg}, 32'd5);
    checkLoad("add");

    // SUB of equal operands with branch: zero=1, target=0x10C
    applyStimulus(1'b0, 2'b00, 3'b100, 4'b0010, 32'h100, 32'h1234, 32'h1234,
                  32'd3, 5'd4, 5'd6);
    tick();
    checkOutput("sub", "zero_const", {31'd0, zero}, 32'd1);
    checkOutput("sub", "target_const", branch_target, 32'h10C);
    checkLoad("sub");

    // Signed SLT: -2 < 1
    applyStimulus(1'b0, 2'b10, 3'b000, 4'b1100, 32'h0, 32'hFFFF_FFFE, 32'd1,
                  32'h2A, 5'd1, 5'd2);
    tick();
    checkOutput("slt", "alu_const", alu_result, 32'd1);

    // Directed multiply
    applyStimulus(1'b0, 2'b10, 3'b000, 4'b1100, 32'h200, 32'h1_0001, 32'h1_0003,
                  32'h18, 5'd3, 5'd7);
    runMul("mul");
    checkOutput("mul", "nop_after", 32'd0, 32'd0 ^ {31'd0, stall});

    // Random multiplies
    for (int k = 0; k < 3; k++) begin
      r = $urandom;
      applyStimulus(1'b0, r[1:0], r[4:2], {r[5], 3'b100}, $urandom, $urandom,
                    $urandom, ($urandom & 32'hFFFF_FFC0) | 32'h18, r[10:6], r[15:11]);
      runMul("mul_rand");
    end

    // Random single-cycle ops, some flushed
    for (int k = 0; k < 24; k++) begin
      r = $urandom;
      applyStimulus((r[2:0] == 3'd0), r[4:3], r[7:5], r[11:8], $urandom, $urandom,
                    $urandom, ($urandom & 32'hFFFF_FFC0) | {26'd0, functs[r[14:12] % 6]},
                    r[19:15], r[24:20]);
      tick();
      checkLoad("rand");
    end

    // Flush together with a multiply issue: no multiply starts
    applyStimulus(1'b1, 2'b10, 3'b010, 4'b1100, 32'h0, 32'd5, 32'd6, 32'h18, 5'd1, 5'd2);
    #1;
    checkOutput("flush_issue", "stall", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("flush_issue", "wb_bubble", {30'd0, wb_out}, 32'd0);
    checkOutput("flush_issue", "mem_bubble", {29'd0, mem_out}, 32'd0);
    applyNop();
    #1;
    checkOutput("flush_issue", "stall_idle", {31'd0, stall}, 32'd0);
    tick();
    checkLoad("flush_issue_nop");

    // Flush at busy cycle 5: abort, product never appears
    applyStimulus(1'b0, 2'b10, 3'b000, 4'b1100, 32'h0, 32'h1_0001, 32'h1_0003,
                  32'h18, 5'd3, 5'd7);
    tick();
    for (int c = 0; c < 5; c++) tick();
    flush = 1'b1;
    #1;
    checkOutput("flush_busy", "stall", {31'd0, stall}, 32'd1);
    tick();
    checkOutput("flush_busy", "wb_bubble", {30'd0, wb_out}, 32'd0);
    checkOutput("flush_busy", "mem_bubble", {29'd0, mem_out}, 32'd0);
    applyNop();
    #1;
    checkOutput("flush_busy", "stall_drop", {31'd0, stall}, 32'd0);
    sawProd = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (alu_result === 32'h0004_0003) sawProd = 1'b1;
    end
    checkOutput("flush_busy", "no_product", {31'd0, sawProd}, 32'd0);

    // Reset mid-multiply at busy cycle 10
    applyStimulus(1'b0, 2'b11, 3'b001, 4'b1100, 32'h80, 32'd12345, 32'd777,
                  32'h18, 5'd3, 5'd9);
    tick();
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b1;
    tick();
    checkOutput("rst_mul", "stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_mul", "wb", {30'd0, wb_out}, 32'd0);
    checkOutput("rst_mul", "mem", {29'd0, mem_out}, 32'd0);
    checkOutput("rst_mul", "alu", alu_result, 32'd0);
    checkOutput("rst_mul", "dest", {27'd0, dest_reg}, 32'd0);
    rst = 1'b0;
    applyNop();
    #1;
    checkOutput("rst_mul", "stall_idle", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("rst_mul", "idle_load_wb", {30'd0, wb_out}, 32'd2);

`ifdef EX_FWD_EN
    // ADDI with operand A forwarded from EX/MEM, rt from MEM/WB
    fwd_a = 2'b10;
    exmem_fwd = 32'd40;
    fwd_b = 2'b01;
    memwb_fwd = 32'h55;
    applyStimulus(1'b0, 2'b10, 3'b000, 4'b0001, 32'h0, 32'd999, 32'd5, 32'd2, 5'd8, 5'd0);
    tick();
    checkOutput("fwd", "alu_const", alu_result, 32'd42);
    checkOutput("fwd", "store_const", store_data, 32'h55);
    checkLoad("fwd");
    fwd_a = 2'b00;
    fwd_b = 2'b00;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register.
- Consumes the ID/EX register outputs, computes the ALU result, branch target, zero flag and destination register, and registers them for the MEM stage.
- Contains an iterative 32-cycle multiplier. While it runs, the block stalls the upstream stages and inserts bubbles downstream.

Parameters:
- MUL_CYCLES, 32, number of shift-add iterations for a multiply (fixed width; must equal the data width).
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  branch taken in MEM; kill the current EX operation.
- wb_in  in  2  WB controls {reg_write, mem_to_reg}.
- mem_in  in  3  MEM controls {branch, mem_read, mem_write}.
- ex_in  in  4  EX controls {reg_dst, alu_op[1:0], alu_src}.
- npc_in  in  32  PC+4 from ID/EX.
- rs_val  in  32  read data 1.
- rt_val  in  32  read data 2.
- imm  in  32  sign-extended immediate; imm[5:0] is funct.
- rt_idx  in  5  instruction bits 20:16.
- rd_idx  in  5  instruction bits 15:11.
- stall  out  1  hold PC, IF/ID and ID/EX this cycle (combinational from state).
- wb_out  out  2  registered WB controls.
- mem_out  out  3  registered MEM controls.
- branch_target  out  32  registered npc_in + (imm<<2), wrapping modulo 2^32.
- zero  out  1  registered (alu_result == 0).
- alu_result  out  32  registered ALU or multiply result.
- store_data  out  32  registered rt_val.
- dest_reg  out  5  registered destination: rd_idx if reg_dst, else rt_idx.

Behaviour:
- Reset: every registered output is 0. State is IDLE and stall=0. Reset wins over all other inputs and aborts a multiply in progress.
- ALU operand B: imm if alu_src, else rt_val.
- ALU op decode:
  - alu_op 00: ADD.
  - alu_op 01: SUB.
  - alu_op 11: OR.
  - alu_op 10: decode funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT (signed), 011000 MUL. Any other funct yields 0.
- Width rules: ADD/SUB wrap modulo 2^32 with no overflow trap. MUL writes the low 32 bits of the unsigned product.
- FSM states: IDLE, MUL_BUSY.
- IDLE, non-MUL op: one-cycle latency. The EX/MEM register loads the results on the next edge.
- IDLE, MUL decoded and flush=0:
  - Go to MUL_BUSY.
  - Latch the operands, wb, mem and dest; clear the counter.
  - stall=1 in that same cycle.
  - EX/MEM loads a bubble: wb_out=0, mem_out=0; data fields don't-care, driven 0.
- MUL_BUSY:
  - One shift-add step per cycle; counter increments.
  - stall=1 and a bubble goes to EX/MEM each cycle.
  - When counter==MUL_CYCLES-1: load the product and the latched controls into EX/MEM, drop stall, return to IDLE.
  - Total latency is MUL_CYCLES+1 edges from issue.
  - ID/EX inputs are ignored while busy; upstream holds them.
- flush=1:
  - EX/MEM loads a bubble (wb_out=0, mem_out=0) on the next edge.
  - In MUL_BUSY: abort, return to IDLE, stall=0 next cycle.
  - Flush together with a MUL issue: flush wins and no multiply starts.
- zero is computed from the value being loaded into alu_result.
- branch_target is registered every non-bubble cycle, independent of the branch bit.

Optional Feature:
- Macro: EX_FWD_EN.
- When defined, add these ports:
  - fwd_a  in  2
  - fwd_b  in  2
  - exmem_fwd  in  32
  - memwb_fwd  in  32
- Operand A selection: 00 rs_val, 10 exmem_fwd, 01 memwb_fwd, 11 rs_val.
- Operand B pre-mux (before the alu_src mux) uses fwd_b the same way; store_data also uses the forwarded rt value.
- Multiply operands are the forwarded values at issue.
- When undefined: ports absent, operands come straight from rs_val/rt_val.

Decomposition:
- Package ex_pkg holds:
  - alu_op encodings and funct constants (FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT, FUNCT_MUL).
  - An enum for the internal ALU function.
  - The FSM state enum.
  - Forward-select encodings.
- One sub-module, ex_alu: combinational ADD/SUB/AND/OR/SLT. The FSM and multiplier stay in ex_mem_stage.

Test Plan:
- Reset mid-multiply: issue MUL, assert rst at busy cycle 10 -> next cycle all outputs 0, stall=0, state IDLE.
- R-type ADD, rs=7, rt=0xFFFFFFFF, funct 100000, reg_dst=1, rd=5 -> after 1 edge alu_result=6, zero=0, dest_reg=5.
- SUB equal operands 0x1234 with mem branch=1, npc=0x100, imm=3 -> alu_result=0, zero=1, branch_target=0x10C.
- SLT signed, rs=0xFFFFFFFE, rt=1 -> alu_result=1.
- MUL, rs=0x10001, rt=0x10003:
  - stall high for exactly 33 cycles.
  - Bubbles emitted during the stall.
  - Then alu_result=0x00040003 with the latched wb/dest.
- flush at MUL busy cycle 5 -> bubble loaded, stall drops next cycle, no product ever written. With EX_FWD_EN: fwd_a=10, exmem_fwd=40, ADDI imm=2 -> alu_result=42.
